// File: rtl/alu_rr_scheduler_pkg.sv
// alu_rr_scheduler_pkg: ALU opcodes and scheduler FSM state encodings
package alu_rr_scheduler_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: requester and response bundle between issuing engines and the scheduler
interface alu_rr_scheduler_if #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [N*NREQ-1:0] req_a;
  logic [N*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_result;
  logic              rsp_zero;
  logic              busy;
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );
endinterface

// File: rtl/alu_rr_scheduler_alu.sv
// n_bit_alu: combinational N-bit ALU with zero flag
module n_bit_alu
  import alu_rr_scheduler_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] operand1,
  input  logic [N-1:0] operand2,
  input  logic [2:0]   control,
  output logic [N-1:0] result,
  output logic         zero
);
  // select the operation; SLT is signed, SLL shifts by the low log2(N) bits of operand2
  always_comb begin
    result = control == ALU_ADD ? operand1 + operand2 :
             control == ALU_SUB ? operand1 - operand2 :
             control == ALU_AND ? operand1 & operand2 :
             control == ALU_OR  ? operand1 | operand2 :
             control == ALU_XOR ? operand1 ^ operand2 :
             control == ALU_NOR ? ~(operand1 | operand2) :
             control == ALU_SLT ? {{(N-1){1'b0}}, $signed(operand1) < $signed(operand2)} :
                                  operand1 << operand2[$clog2(N)-1:0];
    zero = result == '0;
  end
endmodule

// File: rtl/alu_rr_scheduler_arbiter.sv
// rr_arbiter: picks the first asserted request at or above ptr, wrapping at NREQ-1
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  // scan offsets from farthest to nearest so the nearest valid index from ptr wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) begin
        idx = IDW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    grant = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one ALU among NREQ requesters, one op in flight
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic clk,
  input logic rst_n,
  alu_rr_scheduler_if.slave bus
);
  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, idx, id_q;
  logic [NREQ-1:0] grant;
  logic           any, can_arb, accept, zero;
  logic [2:0]     op_q;
  logic [N-1:0]   a_q, b_q, result;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(bus.req_valid), .ptr(rr_ptr), .grant(grant), .idx(idx), .any(any)
  );
  n_bit_alu #(.N(N)) u_alu (
    .operand1(a_q), .operand2(b_q), .control(op_q), .result(result), .zero(zero)
  );
  // arbitrate when idle or when the pending response is being consumed this cycle
  always_comb begin
    can_arb = rst_n && (state == ST_IDLE || (state == ST_RESP && bus.rsp_ready));
    accept = can_arb && any;
    bus.req_ready = can_arb ? grant : '0;
    bus.busy = state != ST_IDLE;
    state_nx = state == ST_EXEC ? ST_RESP :
               state == ST_RESP && !bus.rsp_ready ? ST_RESP :
               accept ? ST_EXEC : ST_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  // operand capture on accept, result capture at the end of EXEC, response drop on handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.req_op[3*idx+:3];
        a_q <= bus.req_a[N*idx+:N];
        b_q <= bus.req_b[N*idx+:N];
        id_q <= idx;
        rr_ptr <= idx == IDW'(NREQ - 1) ? '0 : idx + 1'b1;
      end
      if (state == ST_EXEC) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_id <= id_q;
        bus.rsp_result <= result;
        bus.rsp_zero <= zero;
      end else if (state == ST_RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed checks of arbitration order, latency, backpressure and reset
module tb_alu_rr_scheduler;
  import alu_rr_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  alu_rr_scheduler_if #(.N(32), .NREQ(4), .IDW(2)) bus ();
  alu_rr_scheduler #(.N(32), .NREQ(4), .IDW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[3*i+:3] = op;
    bus.req_a[32*i+:32] = a;
    bus.req_b[32*i+:32] = b;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 0);
    step;
    step;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, ALU_ADD, 32'd15, 32'd12);
    bus.req_valid = 4'b0001;
    #1;
    chk("t1_req_ready", 64'(bus.req_ready), 64'b0001);
    step;
    chk("t1_busy", 64'(bus.busy), 1);
    chk("t1_exec_ready", 64'(bus.req_ready), 0);
    chk("t1_exec_valid", 64'(bus.rsp_valid), 0);
    bus.req_valid = '0;
    step;
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 1);
    chk("t1_rsp_id", 64'(bus.rsp_id), 0);
    chk("t1_rsp_result", 64'(bus.rsp_result), 27);
    chk("t1_rsp_zero", 64'(bus.rsp_zero), 0);
    step;
    chk("t1_idle_valid", 64'(bus.rsp_valid), 0);
    chk("t1_idle_busy", 64'(bus.busy), 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, ALU_SUB, 32'd12, 32'd12);
    bus.req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("t2_grant%0d", n), 64'(bus.req_ready), 64'(4'b0001 << (n % 4)));
      step;
      step;
      chk($sformatf("t2_valid%0d", n), 64'(bus.rsp_valid), 1);
      chk($sformatf("t2_id%0d", n), 64'(bus.rsp_id), 64'(n % 4));
      chk($sformatf("t2_result%0d", n), 64'(bus.rsp_result), 0);
      chk($sformatf("t2_zero%0d", n), 64'(bus.rsp_zero), 1);
    end
    bus.req_valid = '0;
    step;
    bus.rsp_ready = 1'b0;
    set_req(1, ALU_AND, 32'd15, 32'd12);
    bus.req_valid = 4'b0010;
    #1;
    chk("t3_grant1", 64'(bus.req_ready), 64'b0010);
    step;
    set_req(2, ALU_ADD, 32'd1, 32'd2);
    bus.req_valid = 4'b0100;
    step;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("t3_hold_valid%0d", n), 64'(bus.rsp_valid), 1);
      chk($sformatf("t3_hold_id%0d", n), 64'(bus.rsp_id), 1);
      chk($sformatf("t3_hold_result%0d", n), 64'(bus.rsp_result), 12);
      chk($sformatf("t3_hold_ready%0d", n), 64'(bus.req_ready), 0);
      step;
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t3_release_grant", 64'(bus.req_ready), 64'b0100);
    step;
    chk("t3_handshake_drop", 64'(bus.rsp_valid), 0);
    chk("t3_exec_busy", 64'(bus.busy), 1);
    bus.req_valid = '0;
    step;
    chk("t3_next_id", 64'(bus.rsp_id), 2);
    chk("t3_next_result", 64'(bus.rsp_result), 3);
    step;
    set_req(3, ALU_OR, 32'hF0, 32'h0F);
    bus.req_valid = 4'b1000;
    #1;
    chk("t4_grant3", 64'(bus.req_ready), 64'b1000);
    step;
    set_req(1, ALU_XOR, 32'd5, 32'd3);
    bus.req_valid = 4'b1010;
    step;
    chk("t4_id3", 64'(bus.rsp_id), 3);
    chk("t4_result3", 64'(bus.rsp_result), 64'hFF);
    chk("t4_wrap_grant1", 64'(bus.req_ready), 64'b0010);
    step;
    bus.req_valid = '0;
    step;
    chk("t4_id1", 64'(bus.rsp_id), 1);
    chk("t4_result1", 64'(bus.rsp_result), 6);
    step;
    set_req(0, ALU_ADD, 32'd15, 32'd12);
    bus.req_valid = 4'b0001;
    #1;
    chk("t5_grant0", 64'(bus.req_ready), 64'b0001);
    step;
    chk("t5_exec_busy", 64'(bus.busy), 1);
    rst_n = 1'b0;
    set_req(0, ALU_SUB, 32'd15, 32'd12);
    bus.req_valid = 4'b0101;
    #1;
    chk("t5_async_busy", 64'(bus.busy), 0);
    chk("t5_async_ready", 64'(bus.req_ready), 0);
    chk("t5_async_valid", 64'(bus.rsp_valid), 0);
    chk("t5_async_result", 64'(bus.rsp_result), 0);
    step;
    step;
    chk("t5_no_rsp", 64'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    #1;
    chk("t5_post_grant", 64'(bus.req_ready), 64'b0001);
    step;
    bus.req_valid = '0;
    step;
    chk("t5_post_id", 64'(bus.rsp_id), 0);
    chk("t5_post_result", 64'(bus.rsp_result), 3);
    step;
    bus.rsp_ready = 1'b0;
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    set_req(2, ALU_ADD, 32'd100, 32'd1);
    bus.req_valid = 4'b0110;
    #1;
    chk("t6_grant1", 64'(bus.req_ready), 64'b0010);
    step;
    bus.req_valid = 4'b0100;
    set_req(2, ALU_ADD, 32'd200, 32'd1);
    step;
    chk("t6_id1", 64'(bus.rsp_id), 1);
    chk("t6_result1", 64'(bus.rsp_result), 2);
    chk("t6_wait_ready", 64'(bus.req_ready), 0);
    set_req(2, ALU_ADD, 32'd300, 32'd1);
    step;
    set_req(2, ALU_ADD, 32'd400, 32'd1);
    bus.rsp_ready = 1'b1;
    #1;
    chk("t6_grant2", 64'(bus.req_ready), 64'b0100);
    step;
    set_req(2, ALU_ADD, 32'd500, 32'd1);
    bus.req_valid = '0;
    step;
    chk("t6_id2", 64'(bus.rsp_id), 2);
    chk("t6_result2", 64'(bus.rsp_result), 401);
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
